// File: rtl/alu_share_arbiter.sv
// Round-robin owner of a single shared ALU between two requesters.
// It captures the winner's operands, waits a fixed ALU latency, and returns the result only to the owner.
module alu_share_arbiter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  output logic             gnt0,
  output logic             done0,
  output logic [WIDTH-1:0] res0,
  output logic             err0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] res1,
  output logic             err1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_div_by_zero,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             prio, prio_nxt;
  logic             owner, owner_nxt;
  logic             winner;

  logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
  logic             err0_nxt, err1_nxt, alu_start_nxt, busy_nxt;
  logic [WIDTH-1:0] res0_nxt, res1_nxt, alu_a_nxt, alu_b_nxt;
  logic [1:0]       alu_op_nxt;

  // Registers: FSM state, bookkeeping and every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      prio      <= 1'b0;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      res0      <= '0;
      res1      <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      prio      <= prio_nxt;
      owner     <= owner_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      res0      <= res0_nxt;
      res1      <= res1_nxt;
      err0      <= err0_nxt;
      err1      <= err1_nxt;
      alu_a     <= alu_a_nxt;
      alu_b     <= alu_b_nxt;
      alu_op    <= alu_op_nxt;
      alu_start <= alu_start_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    prio_nxt      = prio;
    owner_nxt     = owner;
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
    alu_start_nxt = 1'b0;
    res0_nxt      = res0;
    res1_nxt      = res1;
    err0_nxt      = err0;
    err1_nxt      = err1;
    alu_a_nxt     = alu_a;
    alu_b_nxt     = alu_b;
    alu_op_nxt    = alu_op;
    winner        = (req0 & req1) ? prio : req1;

    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          owner_nxt     = winner;
          alu_a_nxt     = winner ? a1 : a0;
          alu_b_nxt     = winner ? b1 : b0;
          alu_op_nxt    = winner ? op1 : op0;
          gnt0_nxt      = ~winner;
          gnt1_nxt      = winner;
          alu_start_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          if (owner) begin
            res1_nxt  = alu_result;
            err1_nxt  = alu_overflow | alu_div_by_zero;
            done1_nxt = 1'b1;
          end else begin
            res0_nxt  = alu_result;
            err0_nxt  = alu_overflow | alu_div_by_zero;
            done0_nxt = 1'b1;
          end
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        prio_nxt  = ~owner;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instances at ALU latency 1 and 3 share stimulus.
// Each instance is compared against a countdown transaction model, and directed checks cover the key scenarios.
module tb_alu_share_arbiter;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;

  logic [1:0] gnt0_v, gnt1_v, done0_v, done1_v, err0_v, err1_v;
  logic [1:0] start_v, busy_v, ovf_v, dbz_v;
  logic [1:0][W-1:0] res0_v, res1_v, alu_a_v, alu_b_v, alu_res_v;
  logic [1:0][1:0] alu_op_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU: {overflow, div_by_zero, result}
  function automatic logic [5:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] op);
    logic [4:0] s;
    logic [7:0] p;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; return {s[4], 1'b0, s[3:0]}; end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; return {s[4], 1'b0, s[3:0]}; end
      2'd2: begin p = 8'(a) * 8'(b); return {(p > 8'd15), 1'b0, p[3:0]}; end
      default: begin
        if (b == '0) return {1'b0, 1'b1, 4'd0};
        return {1'b0, 1'b0, a / b};
      end
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    alu_share_arbiter #(.WIDTH(W), .ALU_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .op0(op0),
      .gnt0(gnt0_v[g]), .done0(done0_v[g]), .res0(res0_v[g]), .err0(err0_v[g]),
      .req1(req1), .a1(a1), .b1(b1), .op1(op1),
      .gnt1(gnt1_v[g]), .done1(done1_v[g]), .res1(res1_v[g]), .err1(err1_v[g]),
      .alu_a(alu_a_v[g]), .alu_b(alu_b_v[g]), .alu_op(alu_op_v[g]), .alu_start(start_v[g]),
      .alu_result(alu_res_v[g]), .alu_overflow(ovf_v[g]), .alu_div_by_zero(dbz_v[g]),
      .busy(busy_v[g])
    );

    assign {ovf_v[g], dbz_v[g], alu_res_v[g]} = alu_f(alu_a_v[g], alu_b_v[g], alu_op_v[g]);

    // Model: rem counts cycles left in the current transaction (0 = free to grant)
    int rem;
    logic own, prio, win, any_req;
    logic [W-1:0] ma, mb;
    logic [1:0] mop, mg, md, me;
    logic [1:0][W-1:0] mr;
    logic mstart, mbusy;
    logic [5:0] mres;

    assign any_req = req0 | req1;
    assign win     = (req0 & req1) ? prio : req1;
    assign mres    = alu_f(ma, mb, mop);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rem <= 0; own <= 1'b0; prio <= 1'b0;
        ma <= '0; mb <= '0; mop <= '0;
        mg <= '0; md <= '0; me <= '0; mr <= '0;
        mstart <= 1'b0; mbusy <= 1'b0;
      end else begin
        mg <= '0; md <= '0; mstart <= 1'b0;
        if (rem == 0) begin
          mbusy <= any_req;
          if (any_req) begin
            own <= win; rem <= int'(LAT) + 1; mstart <= 1'b1; mg[win] <= 1'b1;
            ma <= win ? a1 : a0; mb <= win ? b1 : b0; mop <= win ? op1 : op0;
          end
        end else begin
          rem <= rem - 1;
          mbusy <= (rem != 1);
          if (rem == 2) begin
            md[own] <= 1'b1;
            mr[own] <= mres[W-1:0];
            me[own] <= mres[5] | mres[4];
          end
          if (rem == 1) prio <= ~own;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("L%0d handshake", LAT),
            32'({gnt1_v[g], gnt0_v[g], done1_v[g], done0_v[g], start_v[g], busy_v[g]}),
            32'({mg[1], mg[0], md[1], md[0], mstart, mbusy}));
      check($sformatf("L%0d results", LAT),
            32'({err1_v[g], res1_v[g], err0_v[g], res0_v[g]}),
            32'({me[1], mr[1], me[0], mr[0]}));
      check($sformatf("L%0d alu_if", LAT),
            32'({alu_op_v[g], alu_b_v[g], alu_a_v[g]}), 32'({mop, mb, ma}));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    cyc(2);
    check("reset busy", 32'(busy_v), 32'd0);
    check("reset res", 32'({res1_v, res0_v}), 32'd0);

    // Single add from requester 0; operand change after grant must be ignored
    rst_n = 1'b1; req0 = 1'b1; a0 = 4'd3; b0 = 4'd4; op0 = 2'd0;
    cyc(1);
    check("s1 gnt0", 32'(gnt0_v), 32'd3);
    check("s1 gnt1", 32'(gnt1_v), 32'd0);
    check("s1 start", 32'(start_v), 32'd3);
    check("s1 alu_ab", 32'({alu_b_v, alu_a_v}), 32'h4433);
    req0 = 1'b0; a0 = 4'd9;
    cyc(1);
    check("s1 L1 done0", 32'(done0_v[0]), 32'd1);
    check("s1 L1 res0", 32'({err0_v[0], res0_v[0]}), 32'h07);
    check("s1 L1 res1", 32'(res1_v[0]), 32'd0);
    check("s1 L3 start", 32'(start_v[1]), 32'd0);
    check("s1 L3 alu_a c2", 32'(alu_a_v[1]), 32'd3);
    cyc(1);
    check("s1 L3 alu_a c3", 32'(alu_a_v[1]), 32'd3);
    check("s1 L3 early done", 32'(done0_v[1]), 32'd0);
    cyc(1);
    check("s1 L3 done0", 32'(done0_v[1]), 32'd1);
    check("s1 L3 res0", 32'(res0_v[1]), 32'd7);
    cyc(2);

    // Divide by zero on requester 1 while a one-cycle req0 pulse arrives mid-EXEC
    req1 = 1'b1; a1 = 4'd5; b1 = 4'd0; op1 = 2'd3;
    cyc(1);
    check("s3 gnt1", 32'(gnt1_v), 32'd3);
    req1 = 1'b0; req0 = 1'b1; a0 = 4'd2; b0 = 4'd2; op0 = 2'd2;
    cyc(1);
    req0 = 1'b0;
    check("s3 L1 done1", 32'({done1_v[0], err1_v[0]}), 32'd3);
    check("s6 no gnt0 a", 32'(gnt0_v), 32'd0);
    cyc(1);
    check("s6 no gnt0 b", 32'(gnt0_v), 32'd0);
    cyc(1);
    check("s3 L3 done1", 32'({done1_v[1], err1_v[1]}), 32'd3);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      check("s6 no gnt0 c", 32'(gnt0_v), 32'd0);
    end

    // Clean add on requester 1 clears the error flag
    req1 = 1'b1; a1 = 4'd1; b1 = 4'd1; op1 = 2'd0;
    cyc(1);
    req1 = 1'b0;
    cyc(1);
    check("s3b L1 res1", 32'({err1_v[0], res1_v[0]}), 32'h02);
    cyc(2);
    check("s3b L3 res1", 32'({done1_v[1], err1_v[1], res1_v[1]}), 32'h22);
    cyc(2);

    // Completed op for requester 0 leaves prio at 1; then reset mid-EXEC
    req0 = 1'b1; a0 = 4'd6; b0 = 4'd7; op0 = 2'd2;
    cyc(1);
    req0 = 1'b0;
    cyc(5);
    req1 = 1'b1; a1 = 4'd2; b1 = 4'd3; op1 = 2'd1;
    cyc(1);
    req1 = 1'b0;
    check("s5 gnt1", 32'(gnt1_v), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("s5 async busy", 32'({busy_v, start_v, gnt1_v}), 32'd0);
    check("s5 async data", 32'({res1_v, res0_v, alu_a_v}), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("s5 no done", 32'({done1_v, done0_v}), 32'd0);
    end

    // Both requesting continuously: grants alternate starting from requester 0
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check("s2 L1 order", 32'({gnt1_v[0], gnt0_v[0]}),
            (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
      check("s2 L3 order", 32'({gnt1_v[1], gnt0_v[1]}),
            (k % 5 == 1) ? (((k / 5) % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(6);

    // Random traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      a0 = W'($urandom); b0 = W'($urandom); op0 = 2'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); op1 = 2'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rnd async busy", 32'(busy_v), 32'd0);
        #1 rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 4-bit ALU between two requesters, e.g. the switch/key panel controller and a self-test pattern generator.
- Round-robin arbitration with a req/gnt/done handshake.
- Captures the winner's operands and op, drives the ALU, and waits a fixed ALU latency.
- Returns the result and error flag to the owning requester only.

Parameters:
WIDTH, 4, operand and result width
ALU_LATENCY, 1, cycles from alu_start cycle to result sample (legal range 1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request level
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
op0  input  2  requester 0 op code (00 add, 01 sub, 10 mul, 11 div)
gnt0  output  1  one-cycle pulse: req0 operands captured
done0  output  1  one-cycle pulse: res0/err0 updated
res0  output  WIDTH  requester 0 last result
err0  output  1  requester 0 last error (overflow or divide-by-zero)
req1, a1, b1, op1, gnt1, done1, res1, err1  same as above, for requester 1
alu_a  output  WIDTH  operand A to ALU
alu_b  output  WIDTH  operand B to ALU
alu_op  output  2  op code to ALU
alu_start  output  1  one-cycle pulse, first EXEC cycle
alu_result  input  WIDTH  ALU result
alu_overflow  input  1  ALU overflow flag
alu_div_by_zero  input  1  ALU divide-by-zero flag
busy  output  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, EXEC, RESP. All outputs are registered.
- Reset (rst_n low, asynchronous): state=IDLE; cnt=0; prio=0; owner=0. All outputs 0: gnt*, done*, res*, err*, alu_a/b/op, alu_start, busy.
- An in-flight operation is dropped by reset; no done pulse follows.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, requester prio wins.
  - On the winning edge: latch a/b/op into alu_a/alu_b/alu_op; owner=winner; gnt_winner=1 and alu_start=1 for the next cycle; cnt=0; go to EXEC.
- EXEC:
  - alu_a/b/op are held stable throughout.
  - alu_start is high only in the first EXEC cycle.
  - cnt increments each cycle.
  - At the edge ending EXEC cycle number ALU_LATENCY (cnt==ALU_LATENCY-1), sample the ALU outputs:
    - res_owner = alu_result.
    - err_owner = alu_overflow | alu_div_by_zero.
    - done_owner = 1 for the next cycle.
  - Then go to RESP.
- RESP: lasts one cycle (done pulse visible). prio = ~owner. Go to IDLE.
- Total latency, req sampled to done high: ALU_LATENCY+1 cycles. Minimum spacing between grants: ALU_LATENCY+2 cycles.
- Handshake rules:
  - A requester holds req and its operands until gnt.
  - Operands are captured at the grant edge; later changes are ignored.
  - Dropping req before gnt withdraws the request with no side effects.
  - A req still high in IDLE after done is a new request.
  - req is ignored in EXEC and RESP; it is never queued, only re-sampled in IDLE.
- Isolation:
  - res/err of the non-owner never change.
  - res_x/err_x hold their value until the next done_x.
  - gnt0&gnt1 and done0&done1 are never high together.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1. With only one requester active, it is granted every ALU_LATENCY+2 cycles regardless of prio.
- Widths: the result is WIDTH bits, taken as given. The arbiter performs no arithmetic except on cnt, which is 4 bits and wraps harmlessly because it is reset on each grant.

Test Plan:
- Reset release, req0=1, a0=3, b0=4, op0=00, ALU_LATENCY=1, ALU returns 7 -> gnt0 pulse at cycle 1; alu_start with alu_a=3, alu_b=4; done0 at cycle 2 with res0=7, err0=0; res1=0 unchanged.
- req0 and req1 high together after reset -> gnt0 first, then gnt1 exactly ALU_LATENCY+2 cycles later; with both held high, grant order is 0,1,0,1 over 4 operations.
- req1: a1=5, b1=0, op1=11, ALU asserts div_by_zero -> done1 with err1=1; next op1=00 with a1=1, b1=1 -> err1 cleared to 0 and res1=2.
- ALU_LATENCY=3: change a0 from 3 to 9 the cycle after gnt0 -> alu_a stays 3 for all 3 EXEC cycles; alu_start high in the first EXEC cycle only; done0 on cycle 4 after request.
- Reset asserted mid-EXEC -> all outputs 0 immediately (asynchronous); no done pulse after release; prio back to 0.
- req0 pulsed high for one cycle while in EXEC serving requester 1, then dropped -> no gnt0 is ever issued.
